// File: rtl/core_write_back.sv
// core_write_back: write-back stage between EXEC and core_reg_file.
// Takes one retiring op and selects its result from the ALU, PC+4 or CSR value.
// For loads it waits for the data-memory response and formats the returned data.
// It then drives one retire pulse per op into the register file.
// Optional feature macro: CORE_WB_FWD_EN adds the forwarding outputs fwd_valid/fwd_id/fwd_value.
// The same macro holds exec_ready low during the cycle a load result is presented.
module core_write_back #(
  parameter int XLEN     = 32,
  parameter int REG_ID_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exec_valid,
  output logic                exec_ready,
  input  logic [1:0]          exec_src,
  input  logic [REG_ID_W-1:0] exec_rd,
  input  logic [XLEN-1:0]     exec_alu,
  input  logic [XLEN-1:0]     exec_pc4,
  input  logic [XLEN-1:0]     exec_csr,
  input  logic [2:0]          exec_funct3,
  input  logic                dmem_rvalid,
  input  logic [XLEN-1:0]     dmem_rdata,
  input  logic                dmem_err,
  output logic                reg_d_en,
  output logic                reg_d_write,
  output logic [REG_ID_W-1:0] reg_d_id,
  output logic [XLEN-1:0]     reg_d_value,
  output logic                wb_fault
`ifdef CORE_WB_FWD_EN
  ,
  output logic                fwd_valid,
  output logic [REG_ID_W-1:0] fwd_id,
  output logic [XLEN-1:0]     fwd_value
`endif
);

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;
  localparam logic [1:0] SRC_CSR  = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } state_t;

  state_t              state_r, state_nxt_s;
  logic [REG_ID_W-1:0] rd_r, rd_nxt_s;
  logic [2:0]          funct3_r, funct3_nxt_s;
  logic [1:0]          off_r, off_nxt_s;
  logic                en_nxt_s, wr_nxt_s, fault_nxt_s;
  logic [REG_ID_W-1:0] id_nxt_s;
  logic [XLEN-1:0]     val_nxt_s;
  logic                hs_s;
  logic                load_ret_nxt_s;

  // funct3 codes 011, 110 and 111 have no load meaning and retire as a fault
  function automatic logic f3_reserved(input logic [2:0] f3);
    logic res;
    case (f3)
      3'b011, 3'b110, 3'b111: res = 1'b1;
      default:                res = 1'b0;
    endcase
    return res;
  endfunction

  // Picks the byte or halfword out of the aligned word and sign- or zero-extends it
  function automatic logic [XLEN-1:0] load_format(input logic [2:0] f3, input logic [1:0] off,
                                                  input logic [XLEN-1:0] w);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    if (off[1]) h = w[31:16];
    else        h = w[15:0];
    case (f3)
      3'b000:  r = {{(XLEN-8){b[7]}}, b};
      3'b001:  r = {{(XLEN-16){h[15]}}, h};
      3'b010:  r = w;
      3'b100:  r = {{(XLEN-8){1'b0}}, b};
      3'b101:  r = {{(XLEN-16){1'b0}}, h};
      default: r = {XLEN{1'b0}};
    endcase
    return r;
  endfunction

`ifdef CORE_WB_FWD_EN
  logic load_ret_r;

  // Remembers that the op on the outputs this cycle is a load result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) load_ret_r <= 1'b0;
    else     load_ret_r <= load_ret_nxt_s;
  end

  assign exec_ready = (state_r == ST_IDLE) & ~load_ret_r;
  assign fwd_valid  = reg_d_en & reg_d_write;
  assign fwd_id     = reg_d_id;
  assign fwd_value  = reg_d_value;
`else
  assign exec_ready = (state_r == ST_IDLE);
`endif

  assign hs_s = exec_valid & exec_ready;

  // Next-state and next-output computation for the IDLE / LOAD_WAIT control
  always_comb begin
    state_nxt_s    = state_r;
    rd_nxt_s       = rd_r;
    funct3_nxt_s   = funct3_r;
    off_nxt_s      = off_r;
    en_nxt_s       = 1'b0;
    wr_nxt_s       = 1'b0;
    fault_nxt_s    = 1'b0;
    id_nxt_s       = reg_d_id;
    val_nxt_s      = reg_d_value;
    load_ret_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (hs_s) begin
          if (exec_src == SRC_LOAD) begin
            rd_nxt_s     = exec_rd;
            funct3_nxt_s = exec_funct3;
            off_nxt_s    = exec_alu[1:0];
            state_nxt_s  = ST_LOAD_WAIT;
          end else begin
            en_nxt_s = 1'b1;
            id_nxt_s = exec_rd;
            wr_nxt_s = (exec_rd != {REG_ID_W{1'b0}});
            case (exec_src)
              SRC_ALU: val_nxt_s = exec_alu;
              SRC_PC4: val_nxt_s = exec_pc4;
              SRC_CSR: val_nxt_s = exec_csr;
              default: val_nxt_s = exec_alu;
            endcase
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD_WAIT: begin
        if (dmem_rvalid) begin
          en_nxt_s       = 1'b1;
          id_nxt_s       = rd_r;
          load_ret_nxt_s = 1'b1;
          state_nxt_s    = ST_IDLE;
          if (dmem_err | f3_reserved(funct3_r)) begin
            fault_nxt_s = 1'b1;
            val_nxt_s   = {XLEN{1'b0}};
          end else begin
            wr_nxt_s  = (rd_r != {REG_ID_W{1'b0}});
            val_nxt_s = load_format(funct3_r, off_r, dmem_rdata);
          end
        end else begin
          state_nxt_s = ST_LOAD_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and the load context captured at handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      rd_r     <= {REG_ID_W{1'b0}};
      funct3_r <= 3'b000;
      off_r    <= 2'b00;
    end else begin
      state_r  <= state_nxt_s;
      rd_r     <= rd_nxt_s;
      funct3_r <= funct3_nxt_s;
      off_r    <= off_nxt_s;
    end
  end

  // Registered register-file write port and fault pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_d_en    <= 1'b0;
      reg_d_write <= 1'b0;
      reg_d_id    <= {REG_ID_W{1'b0}};
      reg_d_value <= {XLEN{1'b0}};
      wb_fault    <= 1'b0;
    end else begin
      reg_d_en    <= en_nxt_s;
      reg_d_write <= wr_nxt_s;
      reg_d_id    <= id_nxt_s;
      reg_d_value <= val_nxt_s;
      wb_fault    <= fault_nxt_s;
    end
  end

endmodule

// File: tb/tb_core_write_back.sv
// Randomized self-checking bench for core_write_back with a behavioural model
// (retire expectations derived from op source, load size and fault rules).
module tb_core_write_back;

  logic        clk = 1'b0;
  logic        rst;
  logic        exec_valid;
  logic        exec_ready;
  logic [1:0]  exec_src;
  logic [4:0]  exec_rd;
  logic [31:0] exec_alu, exec_pc4, exec_csr;
  logic [2:0]  exec_funct3;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        dmem_err;
  logic        reg_d_en, reg_d_write, wb_fault;
  logic [4:0]  reg_d_id;
  logic [31:0] reg_d_value;
`ifdef CORE_WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_id;
  logic [31:0] fwd_value;
`endif

  core_write_back dut (
    .clk(clk), .rst(rst), .exec_valid(exec_valid), .exec_ready(exec_ready),
    .exec_src(exec_src), .exec_rd(exec_rd), .exec_alu(exec_alu), .exec_pc4(exec_pc4),
    .exec_csr(exec_csr), .exec_funct3(exec_funct3), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .dmem_err(dmem_err), .reg_d_en(reg_d_en),
    .reg_d_write(reg_d_write), .reg_d_id(reg_d_id), .reg_d_value(reg_d_value),
    .wb_fault(wb_fault)
`ifdef CORE_WB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_id(fwd_id), .fwd_value(fwd_value)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model state: load outstanding and its context; expected registered outputs
  bit        m_busy;
  bit        m_loadret;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_off;
  logic        e_en, e_wr, e_fault;
  logic [4:0]  e_id;
  logic [31:0] e_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'h0000_00FF;
    h = (w >> (16 * off[1])) & 32'h0000_FFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_loadret = 1'b0; m_rd = 5'd0; m_f3 = 3'd0; m_off = 2'd0;
    e_en = 1'b0; e_wr = 1'b0; e_fault = 1'b0; e_id = 5'd0; e_val = 32'd0;
  endtask

  task automatic check_outputs();
    check("reg_d_en", {31'd0, reg_d_en}, {31'd0, e_en});
    check("reg_d_write", {31'd0, reg_d_write}, {31'd0, e_wr});
    check("wb_fault", {31'd0, wb_fault}, {31'd0, e_fault});
    check("reg_d_id", {27'd0, reg_d_id}, {27'd0, e_id});
    check("reg_d_value", reg_d_value, e_val);
`ifdef CORE_WB_FWD_EN
    check("fwd_valid", {31'd0, fwd_valid}, {31'd0, e_en & e_wr});
    check("fwd_id", {27'd0, fwd_id}, {27'd0, e_id});
    check("fwd_value", fwd_value, e_val);
`endif
  endtask

  task automatic set_idle();
    exec_valid = 1'b0; exec_src = 2'd0; exec_rd = 5'd0; exec_alu = 32'd0;
    exec_pc4 = 32'd0; exec_csr = 32'd0; exec_funct3 = 3'd0;
    dmem_rvalid = 1'b0; dmem_rdata = 32'd0; dmem_err = 1'b0;
  endtask

  // one clock: check ready, advance model from current inputs, check outputs after the edge
  task automatic cycle();
    bit rdy;
    rdy = !m_busy;
`ifdef CORE_WB_FWD_EN
    rdy = rdy && !m_loadret;
`endif
    check("exec_ready", {31'd0, exec_ready}, {31'd0, rdy});
    e_en = 1'b0; e_wr = 1'b0; e_fault = 1'b0; m_loadret = 1'b0;
    if (exec_valid && rdy) begin
      if (exec_src == 2'd1) begin
        m_busy = 1'b1; m_rd = exec_rd; m_f3 = exec_funct3; m_off = exec_alu[1:0];
      end else begin
        e_en = 1'b1; e_id = exec_rd; e_wr = (exec_rd != 5'd0);
        e_val = (exec_src == 2'd0) ? exec_alu : (exec_src == 2'd2) ? exec_pc4 : exec_csr;
      end
    end else if (m_busy && dmem_rvalid) begin
      m_busy = 1'b0; m_loadret = 1'b1; e_en = 1'b1; e_id = m_rd;
      if (dmem_err || m_f3 == 3'd3 || m_f3 == 3'd6 || m_f3 == 3'd7) begin
        e_fault = 1'b1; e_val = 32'd0;
      end else begin
        e_val = ref_load(m_f3, m_off, dmem_rdata); e_wr = (m_rd != 5'd0);
      end
    end
    @(posedge clk); #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic op(input logic [1:0] src, input logic [4:0] rd, input logic [31:0] alu,
                    input logic [2:0] f3);
    set_idle();
    exec_valid = 1'b1; exec_src = src; exec_rd = rd; exec_alu = alu; exec_funct3 = f3;
    exec_pc4 = $urandom; exec_csr = $urandom;
    cycle();
  endtask

  task automatic resp(input logic [31:0] data, input logic err);
    set_idle();
    dmem_rvalid = 1'b1; dmem_rdata = data; dmem_err = err;
    cycle();
  endtask

  task automatic wait_cycle();
    set_idle();
    exec_valid = 1'b1; exec_src = 2'd0; exec_rd = 5'd7; exec_alu = $urandom;
    check("ready_low_waiting", {31'd0, exec_ready}, 32'd0);
    cycle();
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    check("ready_in_reset", {31'd0, exec_ready}, 32'd1);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_idle();
    model_reset();
    #1;
    check_outputs();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // ALU op rd=5
    op(2'd0, 5'd5, 32'h1234_5678, 3'd0);
    check("alu_lit_value", reg_d_value, 32'h1234_5678);
    check("alu_lit_write", {31'd0, reg_d_write}, 32'd1);
    check("alu_lit_id", {27'd0, reg_d_id}, 32'd5);
    set_idle(); cycle();
    check("en_is_pulse", {31'd0, reg_d_en}, 32'd0);
    check("value_holds", reg_d_value, 32'h1234_5678);

    // LB offset 2, response 3 cycles later
    op(2'd1, 5'd9, 32'h0000_1002, 3'd0);
    wait_cycle(); wait_cycle();
    check("ready_low_3", {31'd0, exec_ready}, 32'd0);
    resp(32'h0080_0000, 1'b0);
    check("lb_lit_value", reg_d_value, 32'hFFFF_FF80);
    set_idle(); cycle();

    // LHU / LH offset 2
    op(2'd1, 5'd10, 32'h0000_0002, 3'd5); resp(32'hBEEF_0000, 1'b0);
    check("lhu_lit_value", reg_d_value, 32'h0000_BEEF);
    op(2'd1, 5'd11, 32'h0000_0002, 3'd1); resp(32'hBEEF_0000, 1'b0);
    check("lh_lit_value", reg_d_value, 32'hFFFF_BEEF);
    set_idle(); cycle();

    // x0 write and bus error
    op(2'd0, 5'd0, 32'hCAFE_0001, 3'd0);
    check("x0_en", {31'd0, reg_d_en}, 32'd1);
    check("x0_write", {31'd0, reg_d_write}, 32'd0);
    op(2'd1, 5'd12, 32'h0, 3'd2); resp(32'h1111_2222, 1'b1);
    check("err_fault", {31'd0, wb_fault}, 32'd1);
    check("err_write", {31'd0, reg_d_write}, 32'd0);
    check("err_value", reg_d_value, 32'd0);
    op(2'd1, 5'd13, 32'h0, 3'd6); resp(32'h1111_2222, 1'b0);
    check("rsvd_fault", {31'd0, wb_fault}, 32'd1);
    set_idle(); cycle();

    // reset mid load, then stale rvalid, then normal ALU op
    op(2'd1, 5'd14, 32'h0, 3'd2);
    set_idle(); cycle();
    do_reset();
    resp(32'hDEAD_BEEF, 1'b0);
    check("stale_no_en", {31'd0, reg_d_en}, 32'd0);
    op(2'd0, 5'd15, 32'h0000_ABCD, 3'd0);
    check("post_reset_value", reg_d_value, 32'h0000_ABCD);

    // back-to-back ALU ops rd=1,2,3
    for (int i = 1; i <= 3; i++) begin
      op(2'd0, i[4:0], 32'h100 + i, 3'd0);
      check("b2b_en", {31'd0, reg_d_en}, 32'd1);
      check("b2b_id", {27'd0, reg_d_id}, i);
    end

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      exec_valid  = ($urandom_range(0, 2) != 0);
      exec_src    = 2'($urandom_range(0, 3));
      exec_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      exec_alu    = $urandom;
      exec_pc4    = $urandom;
      exec_csr    = $urandom;
      exec_funct3 = 3'($urandom_range(0, 7));
      dmem_rvalid = ($urandom_range(0, 2) == 0);
      dmem_rdata  = $urandom;
      dmem_err    = ($urandom_range(0, 7) == 0);
      cycle();
      if (k == 1500) do_reset();
    end

    set_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
